// File: rtl/uart_pkg.sv
// +----------------------------------------------------------------------+
// | uart_pkg : shared UART types and constants (RX now, TX successor).   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_sync.sv
// +----------------------------------------------------------------------+
// | uart_rx_sync : 2-flop rx synchronizer plus optional 2-of-3 sampler.  |
// | Build option: UART_RX_MAJORITY_EN enables the majority history.       |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module uart_rx_sync
  import uart_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic s_tick,
  input  logic rx,
  output logic rx_s,
  output logic sample
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= rx;
      r_sync <= r_meta;
    end
  end

  assign rx_s = r_sync;

`ifdef UART_RX_MAJORITY_EN
  // History of the two previous ticks; the current tick's value completes the vote.
  logic [1:0] r_hist;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hist <= 2'b11;
    end else if (s_tick) begin
      r_hist <= {r_hist[0], r_sync};
    end
  end

  assign sample = maj3(r_hist[1], r_hist[0], r_sync);
`else
  logic w_unused_tick;
  assign w_unused_tick = s_tick;
  assign sample        = r_sync;
`endif

endmodule

`default_nettype wire

// File: rtl/uart_rx_frame.sv
// +----------------------------------------------------------------------+
// | uart_rx_frame : oversampling UART receiver with parity/frame checks. |
// | Build option: UART_RX_MAJORITY_EN selects 2-of-3 bit sampling.        |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 s_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_dout,
  output logic                 rx_done_tick,
  output logic                 parity_err,
  output logic                 frame_err
);

  localparam int c_CNT_W = $clog2(OVERSAMPLE);
  localparam int c_IDX_W = $clog2(DATA_BITS);
  localparam logic [c_CNT_W-1:0] c_MID  = c_CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(OVERSAMPLE - 1);
  localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(DATA_BITS - 1);
  localparam logic               c_STOP_LAST = 1'(STOP_BITS - 1);

  generate
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_rx_frame: DATA_BITS must be 5..9");
    end
    if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_bad_oversample
      $error("uart_rx_frame: OVERSAMPLE must be even and >= 8");
    end
    if (PARITY_MODE < PAR_NONE || PARITY_MODE > PAR_ODD) begin : g_bad_parity
      $error("uart_rx_frame: PARITY_MODE must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
      $error("uart_rx_frame: STOP_BITS must be 1 or 2");
    end
  endgenerate

  logic w_rx_s;
  logic w_sample;

  uart_rx_sync u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .s_tick  (s_tick),
    .rx      (rx),
    .rx_s    (w_rx_s),
    .sample  (w_sample)
  );

  rx_state_t            r_state;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [c_IDX_W-1:0]   r_idx;
  logic                 r_sidx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_perr;
  logic                 r_ferr;
  logic                 r_armed;
  logic [DATA_BITS-1:0] r_dout;
  logic                 r_done;
  logic                 r_perr_out;
  logic                 r_ferr_out;

  logic w_par_xor;
  logic w_ferr_final;
  assign w_par_xor    = (^r_shift) ^ w_sample;
  assign w_ferr_final = r_ferr | ~w_sample;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_sidx     <= 1'b0;
      r_shift    <= '0;
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
      r_armed    <= 1'b1;
      r_dout     <= '0;
      r_done     <= 1'b0;
      r_perr_out <= 1'b0;
      r_ferr_out <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_rx_s) r_armed <= 1'b1;

      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (!w_rx_s && r_armed) r_state <= START;
        end

        START: if (s_tick) begin
          if (r_cnt == c_MID) begin
            r_cnt <= '0;
            if (!w_sample) begin
              r_state <= DATA;
              r_idx   <= '0;
              r_perr  <= 1'b0;
              r_ferr  <= 1'b0;
            end else begin
              r_state <= IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        DATA: if (s_tick) begin
          if (r_cnt == c_LAST) begin
            r_cnt          <= '0;
            r_shift[r_idx] <= w_sample;
            if (r_idx == c_IDX_LAST) begin
              r_sidx  <= 1'b0;
              r_state <= (PARITY_MODE != PAR_NONE) ? PARITY : STOP;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        PARITY: if (s_tick) begin
          if (r_cnt == c_LAST) begin
            r_cnt   <= '0;
            r_perr  <= (PARITY_MODE == PAR_ODD) ? ~w_par_xor : w_par_xor;
            r_state <= STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        STOP: if (s_tick) begin
          if (r_cnt == c_LAST) begin
            r_cnt <= '0;
            if (r_sidx == c_STOP_LAST) begin
              // Outputs and pulse land together in the first IDLE cycle.
              r_state    <= IDLE;
              r_done     <= 1'b1;
              r_dout     <= r_shift;
              r_perr_out <= r_perr;
              r_ferr_out <= w_ferr_final;
              if (w_ferr_final) r_armed <= 1'b0;
            end else begin
              r_sidx <= 1'b1;
              r_ferr <= w_ferr_final;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign rx_dout      = r_dout;
  assign rx_done_tick = r_done;
  assign parity_err   = r_perr_out;
  assign frame_err    = r_ferr_out;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_frame.sv
// +----------------------------------------------------------------------+
// | tb_uart_rx_frame : directed bench for 8N1, 8E1 and 7O2 receivers.    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_uart_rx_frame;

  logic       clk     = 1'b0;
  logic       reset_n = 1'b0;
  logic       s_tick;
  logic [1:0] tdiv    = 2'd0;
  logic       rx0 = 1'b1, rx1 = 1'b1, rx2 = 1'b1;

  logic [7:0] dout0, dout1;
  logic [6:0] dout2;
  logic       done0, done1, done2;
  logic       perr0, perr1, perr2;
  logic       ferr0, ferr1, ferr2;

  int checks   = 0;
  int failures = 0;
  int n0 = 0, n1 = 0, n2 = 0;
  int wide = 0;
  logic p0 = 1'b0, p1 = 1'b0, p2 = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) tdiv <= tdiv + 2'd1;
  assign s_tick = (tdiv == 2'd3);

  uart_rx_frame #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_MODE(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .rx(rx0),
    .rx_dout(dout0), .rx_done_tick(done0), .parity_err(perr0), .frame_err(ferr0));

  uart_rx_frame #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_MODE(1), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .rx(rx1),
    .rx_dout(dout1), .rx_done_tick(done1), .parity_err(perr1), .frame_err(ferr1));

  uart_rx_frame #(.DATA_BITS(7), .OVERSAMPLE(16), .PARITY_MODE(2), .STOP_BITS(2)) u_7o2 (
    .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .rx(rx2),
    .rx_dout(dout2), .rx_done_tick(done2), .parity_err(perr2), .frame_err(ferr2));

  always @(negedge clk) begin
    if (done0) n0++;
    if (done1) n1++;
    if (done2) n2++;
    if ((done0 && p0) || (done1 && p1) || (done2 && p2)) wide++;
    p0 = done0;
    p1 = done1;
    p2 = done2;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns #1 after the clock edge on which s_tick was high.
  task automatic wait_tick();
    do @(negedge clk); while (s_tick !== 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic set_rx(input int which, input logic v);
    case (which)
      0:       rx0 = v;
      1:       rx1 = v;
      default: rx2 = v;
    endcase
  endtask

  // One bit period; tick j (1..16) samples the value set just before it.
  task automatic drive_bit(input int which, input logic val, input int gj);
    for (int j = 1; j <= 16; j++) begin
      set_rx(which, (j == gj) ? ~val : val);
      wait_tick();
    end
  endtask

  task automatic send_frame(input int which, input logic [8:0] data, input int nbits,
                            input bit has_par, input logic pbit, input int nstop,
                            input logic stop2, input int gbit, input int gj);
    drive_bit(which, 1'b0, 0);
    for (int i = 0; i < nbits; i++) drive_bit(which, data[i], (i == gbit) ? gj : 0);
    if (has_par) drive_bit(which, pbit, 0);
    drive_bit(which, 1'b1, 0);
    if (nstop == 2) drive_bit(which, stop2, 0);
  endtask

  initial begin
    repeat (5) @(posedge clk);
    #1;
    chk("reset_dout",  {24'd0, dout0}, 32'h0);
    chk("reset_done",  {31'd0, done0}, 32'h0);
    chk("reset_perr",  {31'd0, perr0}, 32'h0);
    chk("reset_ferr",  {31'd0, ferr0}, 32'h0);
    reset_n = 1'b1;
    wait_tick();
    wait_tick();

    // 8N1 0xA5
    send_frame(0, 9'h0A5, 8, 1'b0, 1'b0, 1, 1'b1, -1, 0);
    chk("8n1_pulses", n0, 1);
    chk("8n1_dout",   {24'd0, dout0}, 32'hA5);
    chk("8n1_perr",   {31'd0, perr0}, 32'h0);
    chk("8n1_ferr",   {31'd0, ferr0}, 32'h0);

    // 8E1 0x3C: wrong parity bit, then correct one
    send_frame(1, 9'h03C, 8, 1'b1, 1'b1, 1, 1'b1, -1, 0);
    chk("8e1_bad_dout", {24'd0, dout1}, 32'h3C);
    chk("8e1_bad_perr", {31'd0, perr1}, 32'h1);
    chk("8e1_bad_ferr", {31'd0, ferr1}, 32'h0);
    send_frame(1, 9'h03C, 8, 1'b1, 1'b0, 1, 1'b1, -1, 0);
    chk("8e1_good_perr", {31'd0, perr1}, 32'h0);
    chk("8e1_pulses",    n1, 2);

    // 7O2 0x41, correct odd parity 1, second stop bit 0
    send_frame(2, 9'h041, 7, 1'b1, 1'b1, 2, 1'b0, -1, 0);
    chk("7o2_dout", {25'd0, dout2}, 32'h41);
    chk("7o2_ferr", {31'd0, ferr2}, 32'h1);
    chk("7o2_perr", {31'd0, perr2}, 32'h0);
    drive_bit(2, 1'b1, 0);
    drive_bit(2, 1'b1, 0);
    for (int b = 0; b < 30; b++) drive_bit(2, 1'b0, 0);
    chk("break_pulses", n2, 2);
    chk("break_dout",   {25'd0, dout2}, 32'h0);
    chk("break_ferr",   {31'd0, ferr2}, 32'h1);
    chk("break_perr",   {31'd0, perr2}, 32'h1);
    drive_bit(2, 1'b1, 0);
    drive_bit(2, 1'b1, 0);
    chk("break_release_pulses", n2, 2);

    // Start-bit glitch: low for 4 ticks only
    for (int j = 0; j < 4; j++) begin
      set_rx(0, 1'b0);
      wait_tick();
    end
    drive_bit(0, 1'b1, 0);
    drive_bit(0, 1'b1, 0);
    chk("glitch_pulses", n0, 1);
    chk("glitch_dout",   {24'd0, dout0}, 32'hA5);

    // Back-to-back frames, then reset during the third
    send_frame(0, 9'h055, 8, 1'b0, 1'b0, 1, 1'b1, -1, 0);
    chk("b2b_first_dout",   {24'd0, dout0}, 32'h55);
    chk("b2b_first_pulses", n0, 2);
    send_frame(0, 9'h0AA, 8, 1'b0, 1'b0, 1, 1'b1, -1, 0);
    chk("b2b_second_dout",   {24'd0, dout0}, 32'hAA);
    chk("b2b_second_pulses", n0, 3);
    drive_bit(0, 1'b0, 0);
    drive_bit(0, 1'b1, 0);
    drive_bit(0, 1'b1, 0);
    drive_bit(0, 1'b1, 0);
    reset_n = 1'b0;
    set_rx(0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("midreset_dout", {24'd0, dout0}, 32'h0);
    chk("midreset_done", {31'd0, done0}, 32'h0);
    chk("midreset_perr", {31'd0, perr0}, 32'h0);
    chk("midreset_ferr", {31'd0, ferr0}, 32'h0);
    reset_n = 1'b1;
    wait_tick();
    for (int b = 0; b < 12; b++) drive_bit(0, 1'b1, 0);
    chk("midreset_pulses", n0, 3);

    // Single-tick glitch inside data bit 3 of 0xFF
`ifdef UART_RX_MAJORITY_EN
    send_frame(0, 9'h0FF, 8, 1'b0, 1'b0, 1, 1'b1, 3, 7);
    chk("majority_dout", {24'd0, dout0}, 32'hFF);
`else
    send_frame(0, 9'h0FF, 8, 1'b0, 1'b0, 1, 1'b1, 3, 8);
    chk("single_sample_dout", {24'd0, dout0}, 32'hF7);
`endif
    chk("glitch_frame_pulses", n0, 4);
    chk("glitch_frame_ferr",   {31'd0, ferr0}, 32'h0);

    chk("pulse_width", wide, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
